// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory/MIO port between instruction fetch (read-only)
//            and the load/store stage. Runs one bus transaction at a time over
//            a req/ready handshake and returns a one-cycle valid plus rdata.
//            Data has priority over fetch, a burst limit keeps fetch from
//            starving, and a timeout turns a hung bus into an error completion.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_D_BURST    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    // instruction fetch side
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_stall_o,
    // data (load/store) side
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [2:0]  d_type_i,
    output logic [31:0] d_rdata_o,
    output logic        d_valid_o,
    output logic        d_stall_o,
    // memory bus side
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [2:0]  mem_type_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        bus_err_o
);

    localparam int BURST_W = $clog2(MAX_D_BURST + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);
    localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS_D = 2'd1,
        S_BUS_I = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic               own_data_q, own_data_d;   // 1: data owns the bus, 0: fetch
    logic [BURST_W-1:0] burst_q,    burst_d;
    logic [TMO_W-1:0]   tmo_q,      tmo_d;
    logic               err_q,      err_d;
    logic [31:0]        rdata_q,    rdata_d;
    logic               we_q,       we_d;
    logic [31:0]        addr_q,     addr_d;
    logic [31:0]        wdata_q,    wdata_d;
    logic [2:0]         type_q,     type_d;

    logic               arb_en;
    logic               d_elig;
    logic               i_elig;
    logic               grant_d;
    logic               grant_i;
    logic [TMO_W-1:0]   tmo_inc;

    // Arbitration is open in IDLE and DONE; in DONE the requester that just
    // completed is masked so its still-high req cannot regrant immediately.
    assign arb_en  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign d_elig  = arb_en && d_req_i  && !((state_q == S_DONE) &&  own_data_q);
    assign i_elig  = arb_en && if_req_i && !((state_q == S_DONE) && !own_data_q);
    assign grant_d = d_elig && !((burst_q == BURST_MAX) && i_elig);
    assign grant_i = i_elig && !grant_d;
    assign tmo_inc = tmo_q + 1'b1;

    // Next-state logic: grants latch the bus fields, BUS waits for ready or timeout.
    always_comb begin
        state_d    = state_q;
        own_data_d = own_data_q;
        burst_d    = burst_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        type_d     = type_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (grant_d) begin
                    state_d    = S_BUS_D;
                    own_data_d = 1'b1;
                    we_d       = d_we_i;
                    addr_d     = d_addr_i;
                    wdata_d    = d_wdata_i;
                    type_d     = d_type_i;
                    tmo_d      = '0;
                    err_d      = 1'b0;
                    // Only data grants that bypass a waiting fetch count toward the limit.
                    if (if_req_i) begin
                        if (burst_q != BURST_MAX) begin
                            burst_d = burst_q + 1'b1;
                        end
                    end else begin
                        burst_d = '0;
                    end
                end else if (grant_i) begin
                    state_d    = S_BUS_I;
                    own_data_d = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = if_addr_i;
                    wdata_d    = '0;
                    type_d     = 3'b000;
                    tmo_d      = '0;
                    err_d      = 1'b0;
                    burst_d    = '0;
                end
            end
            S_BUS_D, S_BUS_I: begin
                if (mem_ready_i) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : mem_rdata_i;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            own_data_q <= 1'b0;
            burst_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            type_q     <= '0;
        end else begin
            state_q    <= state_d;
            own_data_q <= own_data_d;
            burst_q    <= burst_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            type_q     <= type_d;
        end
    end

    assign mem_req_o   = (state_q == S_BUS_D) || (state_q == S_BUS_I);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_type_o  = type_q;

    assign d_valid_o   = (state_q == S_DONE) &&  own_data_q;
    assign if_valid_o  = (state_q == S_DONE) && !own_data_q;
    assign d_rdata_o   = d_valid_o  ? rdata_q : 32'h0;
    assign if_rdata_o  = if_valid_o ? rdata_q : 32'h0;
    assign bus_err_o   = (state_q == S_DONE) && err_q;

    assign if_stall_o  = if_req_i && !if_valid_o;
    assign d_stall_o   = d_req_i  && !d_valid_o;

endmodule
`default_nettype wire
